// File: rtl/arf_pkg.sv
// Shared constants and types for the ARF accumulation stage.
// The optional overflow flag is enabled by defining ARF_ACC_OVF_EN.
package arf_pkg;

    // Datapath width of products and sums.
    localparam int DATA_W = 32;

    // Adder selection encodings.
    localparam int ADD_AMA32 = 0;
    localparam int ADD_AMA28 = 1;
    localparam int ADD_AMA24 = 2;
    localparam int ADD_EXACT = 3;

    // Number of low-order bits built from approximate mirror-adder cells.
    // Their carry chain is cut.
    // The carry into the exact upper part is speculated from the top approximate bit pair.
    localparam int AMA_LOW_W = 4;

    // Accumulator FSM states.
    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } arf_state_e;

endpackage

// File: rtl/arf_add_sel.sv
// Combinational adder wrapper.
// It elaborates exactly one of add_0 / add_1 / add_2 / add_x, chosen by ADD_SEL, with Cin = 0.
// AMA variants behave as follows:
// - The low AMA_LOW_W bits are summed modulo 2^AMA_LOW_W, and their true carry is dropped.
// - The carry into the upper part is speculated as OR of the top low-part operand bits.
// - The 28b variant sign-extends its result from bit 27.
// - The 24b variant zero-extends its result from bit 23.
module arf_add_sel
    import arf_pkg::*;
#(
    parameter int ADD_SEL = ADD_EXACT
) (
    output logic [DATA_W-1:0] out,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1
);

    if (ADD_SEL == ADD_EXACT) begin : g_add_x
        // Accurate modulo-2^32 sum.
        assign out = in_0 + in_1;
    end else begin : g_ama
        localparam int AW = (ADD_SEL == ADD_AMA28) ? 28 :
                            (ADD_SEL == ADD_AMA24) ? 24 : DATA_W;
        localparam int HW = AW - AMA_LOW_W;

        logic [AMA_LOW_W-1:0] lo;
        logic [HW-1:0]        hi;
        logic                 c_spec;
        logic [AW-1:0]        s;

        assign lo     = in_0[AMA_LOW_W-1:0] + in_1[AMA_LOW_W-1:0];
        assign c_spec = in_0[AMA_LOW_W-1] | in_1[AMA_LOW_W-1];
        assign hi     = in_0[AW-1:AMA_LOW_W] + in_1[AW-1:AMA_LOW_W] + HW'(c_spec);
        assign s      = {hi, lo};

        if (ADD_SEL == ADD_AMA28) begin : g_add_1
            logic unused_top;
            assign unused_top = ^{in_0[DATA_W-1:AW], in_1[DATA_W-1:AW]};
            assign out = {{(DATA_W-AW){s[AW-1]}}, s};
        end else if (ADD_SEL == ADD_AMA24) begin : g_add_2
            logic unused_top;
            assign unused_top = ^{in_0[DATA_W-1:AW], in_1[DATA_W-1:AW]};
            assign out = {{(DATA_W-AW){1'b0}}, s};
        end else begin : g_add_0
            assign out = s;
        end
    end

endmodule

// File: rtl/arf_mac_acc.sv
// Streaming accumulator: sums N_TERMS products through the selected adder.
// The finished sum is presented on a valid/ready output.
// Defining ARF_ACC_OVF_EN adds a sticky signed-overflow flag on out_ovf.
// Otherwise out_ovf is tied to 0.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// A producer holds data while valid is high and ready is low.
// in_ready is 1 only in ACC.
// out_valid is 1 only in DONE.
// out_data is stable for the whole of DONE.
module arf_mac_acc
    import arf_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ADD_SEL = ADD_EXACT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    localparam int CNT_W = $clog2(N_TERMS);
    localparam logic [0:0] S_ACC  = ST_ACC;
    localparam logic [0:0] S_DONE = ST_DONE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] sum;
    logic              accept;
    logic              last;

    arf_add_sel #(
        .ADD_SEL (ADD_SEL)
    ) u_add (
        .out  (sum),
        .in_0 (acc_q),
        .in_1 (in_data)
    );

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign accept    = in_valid & in_ready;
    assign last      = (cnt_q == CNT_LAST);

    // Next-state logic: accumulate accepted terms, close the sum on the last one, wait in DONE for the consumer.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            S_ACC: begin
                if (accept) begin
                    if (last) begin
                        out_data_d = sum;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = S_DONE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    // State registers; reset discards any partial or pending sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef ARF_ACC_OVF_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic out_ovf_q, out_ovf_d;
    logic add_ovf;

    assign add_ovf = (acc_q[DATA_W-1] == in_data[DATA_W-1]) &&
                     (sum[DATA_W-1] != acc_q[DATA_W-1]);

    // Overflow tracking: any overflow in a sum is remembered and published with that sum.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        out_ovf_d    = out_ovf_q;
        if (accept) begin
            if (last) begin
                out_ovf_d    = ovf_sticky_q | add_ovf;
                ovf_sticky_d = 1'b0;
            end else begin
                ovf_sticky_d = ovf_sticky_q | add_ovf;
            end
        end
    end

    // Overflow flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
            out_ovf_q    <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_arf_mac_acc.sv
// Directed bench for arf_mac_acc.
// It uses an exact-adder instance (N_TERMS=4) and an AMA28 instance that share one input stream.
// Build with ARF_ACC_OVF_EN defined to exercise the overflow flag.
module tb_arf_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_data;
    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [31:0] a_out_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

`ifdef ARF_ACC_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // Clock.
    always #5 clk = ~clk;

    arf_mac_acc #(.N_TERMS(4), .ADD_SEL(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    arf_mac_acc #(.N_TERMS(4), .ADD_SEL(1)) dut_ama28 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf)
    );

    // Golden 28b AMA.
    // Start from the exact 28-bit sum.
    // Remove the true low-nibble carry and insert the speculated one (a[3] | b[3]).
    // Then sign-extend from bit 27.
    function automatic logic [31:0] ama28_ref(input logic [31:0] a, input logic [31:0] b);
        logic [27:0] s;
        logic [4:0]  low5;
        s    = a[27:0] + b[27:0];
        low5 = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        s    = s - {23'd0, low5[4], 4'd0} + {23'd0, a[3] | b[3], 4'd0};
        return {{4{s[27]}}, s};
    endfunction

    // Driver: offer four terms back-to-back from a negedge in ACC.
    // It returns at the negedge where the FSM sits in DONE.
    task automatic send_sum(input logic [31:0] t0, input logic [31:0] t1,
                            input logic [31:0] t2, input logic [31:0] t3);
        logic [31:0] t [4];
        t = '{t0, t1, t2, t3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = t[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    endtask

    task automatic test_basic;
        logic [31:0] terms [4];
        logic [31:0] exp_v;
        terms = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_q.push_back(32'd10);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready term %0d got %b want 1", i, in_ready); end
            in_valid = 1'b1;
            in_data  = terms[i];
            @(negedge clk);
        end
        // Offer junk while in DONE; it must be ignored.
        in_data = 32'hDEAD_BEEF;
        exp_v = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        checks++; if (out_data !== exp_v) begin errors++; $display("FAIL basic_out_data got %h want %h", out_data, exp_v); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_in_ready got %b want 0", in_ready); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_out_ovf got %b want 0", out_ovf); end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_bubble_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_all_ones;
        logic [31:0] exp_v;
        exp_q.push_back(32'hFFFF_FFFC);
        send_sum(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_v = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_out_valid got %b want 1", out_valid); end
        checks++; if (out_data !== exp_v) begin errors++; $display("FAIL ones_out_data got %h want %h", out_data, exp_v); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ones_out_ovf got %b want 0", out_ovf); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_v;
        exp_q.push_back(32'd34);
        exp_q.push_back(32'd1000);
        send_sum(32'd7, 32'd8, 32'd9, 32'd10);
        exp_v = exp_q.pop_front();
        checks++; if (out_data !== exp_v) begin errors++; $display("FAIL b2b_first got %h want %h", out_data, exp_v); end
        @(negedge clk);
        send_sum(32'd100, 32'd200, 32'd300, 32'd400);
        exp_v = exp_q.pop_front();
        checks++; if (out_data !== exp_v) begin errors++; $display("FAIL b2b_second got %h want %h", out_data, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_idle_hold;
        logic [31:0] terms [4];
        int          gaps  [4];
        terms = '{32'd1, 32'd2, 32'd3, 32'd4};
        gaps  = '{2, 1, 0, 0};
        exp_q.push_back(32'd10);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = terms[i];
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 32'h5555_5555;
            for (int g = 0; g < gaps[i]; g++) @(negedge clk);
        end
        in_data = '0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL idle_out_valid got %b want 1", out_valid); end
        checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL idle_out_data got %h want %h", out_data, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_ovf;
        send_sum(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        checks++; if (out_data !== 32'h8000_0000) begin errors++; $display("FAIL ovf_out_data got %h want 80000000", out_data); end
        checks++; if (out_ovf !== OVF_EN) begin errors++; $display("FAIL ovf_flag_set got %b want %b", out_ovf, OVF_EN); end
        @(negedge clk);
        send_sum(32'd1, 32'd1, 32'd1, 32'd1);
        checks++; if (out_data !== 32'd4) begin errors++; $display("FAIL ovf_next_data got %h want 4", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_flag_cleared got %b want 0", out_ovf); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send_sum(32'd10, 32'd20, 32'd30, 32'd40);
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d got %b want 1", k, out_valid); end
            checks++; if (out_data !== 32'd100) begin errors++; $display("FAIL bp_out_data cycle %0d got %h want 64", k, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, in_ready); end
            in_valid = 1'b1;
            in_data  = 32'h0000_1234;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        send_sum(32'd1, 32'd1, 32'd1, 32'd1);
        checks++; if (out_data !== 32'd4) begin errors++; $display("FAIL bp_junk_ignored got %h want 4", out_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sum;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'd5; @(negedge clk);
        in_data = 32'd6; @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_output step %0d got %b want 0", i, out_valid); end
            in_valid = 1'b1; in_data = 32'd1; @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_output step 3 got %b want 0", out_valid); end
        in_data = 32'd1; @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        checks++; if (out_data !== 32'd4) begin errors++; $display("FAIL rmid_sum got %h want 4", out_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_done;
        out_ready = 1'b0;
        send_sum(32'd9, 32'd9, 32'd9, 32'd9);
        checks++; if (out_data !== 32'd36) begin errors++; $display("FAIL rdone_pending got %h want 24", out_data); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdone_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rdone_out_data got %h want 0", out_data); end
    endtask

    task automatic test_ama28;
        logic [31:0] terms [4];
        logic [31:0] model;
        terms = '{32'h07FF_FFFF, 32'd1, 32'd0, 32'd0};
        model = '0;
        for (int i = 0; i < 4; i++) model = ama28_ref(model, terms[i]);
        send_sum(terms[0], terms[1], terms[2], terms[3]);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL ama28_out_valid got %b want 1", a_out_valid); end
        checks++; if (a_out_data !== model) begin errors++; $display("FAIL ama28_model got %h want %h", a_out_data, model); end
        checks++; if (a_out_data !== 32'hF800_0010) begin errors++; $display("FAIL ama28_hand got %h want f8000010", a_out_data); end
        checks++; if (out_data !== 32'h0800_0000) begin errors++; $display("FAIL ama28_exact_ref got %h want 08000000", out_data); end
        @(negedge clk);
    endtask

    // Watchdog: the directed sequence is short; stop hard if it ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Test sequence and final report.
    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_back_to_back();
        test_idle_hold();
        test_ovf();
        test_backpressure();
        test_reset_mid_sum();
        test_reset_in_done();
        test_ama28();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
